bcd_to_bin: RTL and testbench

//  Sequential BCD-to-binary converter using reverse double dabble: shift right, then subtract 3 from every digit >= 8.

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_digit_adj.sv | 12 +
 rtl/bcd_to_bin.sv | 110 +++++++++++
 tb/tb_bcd_to_bin.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants for the BCD-to-binary converter: FSM encoding, digit-adjust
// thresholds and the iteration-counter width helper.
package bcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    ADJUST,
    DONE
  } state_t;

  localparam int                 DIGIT_W    = 4;
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd8;
  localparam logic [DIGIT_W-1:0] ADJ_SUB    = 4'd3;

  // Counter must be able to hold BIN_W itself, the terminal shift count.
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of reverse double dabble: subtract 3 from
// any digit that reached 8 or more after a right shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);

  assign q = (d >= ADJ_THRESH) ? d - ADJ_SUB : d;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double dabble, en/rdy handshake).
// Optional invalid-digit detection is enabled by defining BCD_TO_BIN_CHECK_EN.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [DIGIT_W*DIGITS-1:0] bcd_d_in,
  output logic [BIN_W-1:0]          bin_d_out,
  output logic                      rdy,
  output logic                      busy,
  output logic                      err
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = cnt_width(BIN_W);

  state_t                         state;
  logic [BCD_W-1:0]               bcd_q;
  logic [SR_W-1:0]                sr;
  logic [CNT_W-1:0]               cnt;
  logic [CNT_W-1:0]               cnt_nxt;
  logic [DIGITS-1:0][DIGIT_W-1:0] dig;
  logic [DIGITS-1:0][DIGIT_W-1:0] dig_adj;

  assign dig     = sr[SR_W-1:BIN_W];
  assign cnt_nxt = cnt + 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (dig[g]),
      .q (dig_adj[g])
    );
  end

`ifdef BCD_TO_BIN_CHECK_EN
  logic flag;
  logic bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_q[i*DIGIT_W +: DIGIT_W] > 4'd9) bad_digit = 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bcd_q     <= '0;
      sr        <= '0;
      cnt       <= '0;
      bin_d_out <= '0;
      rdy       <= 1'b0;
      busy      <= 1'b0;
`ifdef BCD_TO_BIN_CHECK_EN
      flag      <= 1'b0;
      err       <= 1'b0;
`endif
    end else begin
      rdy <= 1'b0;
      case (state)
        IDLE: if (en) begin
          bcd_q <= bcd_d_in;
          busy  <= 1'b1;
          state <= SETUP;
        end
        SETUP: begin
          sr    <= {bcd_q, {BIN_W{1'b0}}};
          cnt   <= '0;
          state <= SHIFT;
`ifdef BCD_TO_BIN_CHECK_EN
          flag  <= bad_digit;
          err   <= 1'b0;
`endif
        end
        // The final shift goes straight to DONE; no correction follows it.
        SHIFT: begin
          sr    <= sr >> 1;
          cnt   <= cnt_nxt;
          state <= (cnt_nxt == CNT_W'(BIN_W)) ? DONE : ADJUST;
        end
        ADJUST: begin
          sr    <= {dig_adj, sr[BIN_W-1:0]};
          state <= SHIFT;
        end
        DONE: begin
`ifdef BCD_TO_BIN_CHECK_EN
          bin_d_out <= flag ? '0 : sr[BIN_W-1:0];
          err       <= flag;
`else
          bin_d_out <= sr[BIN_W-1:0];
`endif
          rdy   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed-vector bench for bcd_to_bin: latency, handshake, reset abort,
// back-to-back operation and (with BCD_TO_BIN_CHECK_EN) invalid-digit flagging.
module tb_bcd_to_bin;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int LAT    = 2 * BIN_W + 1;

  logic                  clk;
  logic                  rst_n;
  logic                  en;
  logic [4*DIGITS-1:0]   bcd_d_in;
  logic [BIN_W-1:0]      bin_d_out;
  logic                  rdy;
  logic                  busy;
  logic                  err;

  int n_vec;
  int n_fail;

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bcd_d_in  (bcd_d_in),
    .bin_d_out (bin_d_out),
    .rdy       (rdy),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_idle_outputs(input string name);
    n_vec++;
    if ({bin_d_out, rdy, busy, err} !== '0) begin
      n_fail++;
      $display("FAIL %s: bin=%0d rdy=%b busy=%b err=%b, required all 0",
               name, bin_d_out, rdy, busy, err);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    en       = 1'b0;
    bcd_d_in = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset_idle");
  endtask

  // Pulses en for one clock, then watches 60 cycles after the sampling edge.
  // Input is scrambled after sampling; optional re-pulses of en mid-flight.
  task automatic run_conv(input logic [15:0] bcd, input logic [BIN_W-1:0] exp_bin,
                          input logic exp_err, input string name, input bit repulse);
    int first_rdy = -1;
    int n_rdy     = 0;
    bit busy_bad  = 0;
    logic [BIN_W-1:0] got_bin = '0;
    logic got_err = 1'b0;
    @(negedge clk);
    en       = 1'b1;
    bcd_d_in = bcd;
    @(negedge clk);
    en       = 1'b0;
    bcd_d_in = ~bcd;
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      en = repulse && (c == 5 || c == 20);
      if (rdy) begin
        n_rdy++;
        if (first_rdy < 0) begin
          first_rdy = c;
          got_bin   = bin_d_out;
          got_err   = err;
        end
      end
      if (busy !== (c < LAT)) busy_bad = 1;
    end
    en = 1'b0;
    n_vec++;
    if (first_rdy != LAT) begin
      n_fail++;
      $display("FAIL %s_latency: rdy at cycle %0d, required %0d", name, first_rdy, LAT);
    end
    n_vec++;
    if (n_rdy != 1) begin
      n_fail++;
      $display("FAIL %s_rdy_count: %0d pulses, required 1", name, n_rdy);
    end
    n_vec++;
    if (busy_bad) begin
      n_fail++;
      $display("FAIL %s_busy: busy profile wrong, required high for cycles 1..%0d only", name, LAT-1);
    end
    n_vec++;
    if (got_bin !== exp_bin) begin
      n_fail++;
      $display("FAIL %s_result: got 0x%0h, required 0x%0h", name, got_bin, exp_bin);
    end
    n_vec++;
    if (got_err !== exp_err) begin
      n_fail++;
      $display("FAIL %s_err: got %b, required %b", name, got_err, exp_err);
    end
  endtask

  task automatic test_convert();
    run_conv(16'h0000, 14'd0,    1'b0, "zero",  0);
    run_conv(16'h9999, 14'h270F, 1'b0, "max",   0);
    run_conv(16'h4095, 14'h0FFF, 1'b0, "4095",  0);
    run_conv(16'h1234, 14'h04D2, 1'b0, "1234",  0);
    run_conv(16'h0001, 14'd1,    1'b0, "one",   0);
  endtask

  task automatic test_en_while_busy();
    run_conv(16'h0042, 14'd42, 1'b0, "repulse", 1);
  endtask

  task automatic test_reset_abort();
    int n_rdy = 0;
    @(negedge clk);
    en       = 1'b1;
    bcd_d_in = 16'h9999;
    @(negedge clk);
    en = 1'b0;
    for (int c = 1; c < 50; c++) begin
      @(negedge clk);
      if (c == 12) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort_async");
      end else if (c == 13) begin
        rst_n = 1'b1;
      end
      if (rdy) n_rdy++;
    end
    n_vec++;
    if (n_rdy != 0) begin
      n_fail++;
      $display("FAIL abort_no_rdy: %0d pulses, required 0", n_rdy);
    end
    check_idle_outputs("abort_outputs");
    run_conv(16'h9999, 14'd9999, 1'b0, "after_abort", 0);
  endtask

  task automatic test_back_to_back();
    int n_rdy = 0;
    int guard = 0;
    @(negedge clk);
    en       = 1'b1;
    bcd_d_in = 16'h0100;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rdy) begin
        n_rdy++;
        n_vec++;
        if (c != LAT + 30 * (n_rdy - 1) || bin_d_out !== 14'd100) begin
          n_fail++;
          $display("FAIL b2b_pulse%0d: cycle %0d result %0d, required cycle %0d result 100",
                   n_rdy, c, bin_d_out, LAT + 30 * (n_rdy - 1));
        end
      end
    end
    en = 1'b0;
    n_vec++;
    if (n_rdy != 3) begin
      n_fail++;
      $display("FAIL b2b_count: %0d pulses in 100 cycles, required 3", n_rdy);
    end
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (busy) begin
      n_fail++;
      $display("FAIL b2b_drain: busy still %b after 100 cycles, required 0", busy);
    end
    @(negedge clk);
  endtask

  task automatic test_invalid_digit();
`ifdef BCD_TO_BIN_CHECK_EN
    run_conv(16'h00A0, 14'd0,  1'b1, "invalid", 0);
    run_conv(16'h0010, 14'd10, 1'b0, "valid_after_invalid", 0);
`else
    @(negedge clk);
    en       = 1'b1;
    bcd_d_in = 16'h00A0;
    @(negedge clk);
    en = 1'b0;
    repeat (LAT) @(negedge clk);
    n_vec++;
    if (rdy !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_nocheck: rdy=%b err=%b, required rdy=1 err=0", rdy, err);
    end
    run_conv(16'h0010, 14'd10, 1'b0, "valid_after_invalid", 0);
`endif
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    test_reset();
    test_convert();
    test_en_while_busy();
    test_reset_abort();
    test_back_to_back();
    test_invalid_digit();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
